// File: rtl/search_window_agen_if.sv
// search_window_agen_if: request, geometry-result and address-stream signals
// of the search-window address generator.
// master = the generator itself, slave = requester / SRAM-reader side.
interface search_window_agen_if #(
  parameter int IDX_W   = 3,
  parameter int OFF_W   = 4,
  parameter int DIM_W   = 5,
  parameter int COORD_W = 8,
  parameter int LIN_W   = 12
);
  logic               req_valid;
  logic               req_ready;
  logic [IDX_W-1:0]   req_blk_row;
  logic [IDX_W-1:0]   req_blk_col;
  logic [OFF_W-1:0]   req_rel_row;
  logic [OFF_W-1:0]   req_rel_col;
  logic [OFF_W-1:0]   req_off_row;
  logic [OFF_W-1:0]   req_off_col;
  logic [DIM_W-1:0]   req_h;
  logic [DIM_W-1:0]   req_w;
  logic [DIM_W-1:0]   eff_h;
  logic [DIM_W-1:0]   eff_w;
  logic [DIM_W-1:0]   pad_row;
  logic [DIM_W-1:0]   pad_col;
  logic               addr_valid;
  logic               addr_ready;
  logic [COORD_W-2:0] addr_row;
  logic [COORD_W-2:0] addr_col;
  logic [DIM_W-1:0]   win_row;
  logic [DIM_W-1:0]   win_col;
  logic [LIN_W-1:0]   addr_lin;
  logic               addr_last;
  logic               done;

  modport master (
    input  req_valid, req_blk_row, req_blk_col, req_rel_row, req_rel_col,
           req_off_row, req_off_col, req_h, req_w, addr_ready,
    output req_ready, eff_h, eff_w, pad_row, pad_col, addr_valid, addr_row,
           addr_col, win_row, win_col, addr_lin, addr_last, done
  );

  modport slave (
    output req_valid, req_blk_row, req_blk_col, req_rel_row, req_rel_col,
           req_off_row, req_off_col, req_h, req_w, addr_ready,
    input  req_ready, eff_h, eff_w, pad_row, pad_col, addr_valid, addr_row,
           addr_col, win_row, win_col, addr_lin, addr_last, done
  );
endinterface

// File: rtl/search_window_agen.sv
// search_window_agen: turns a block-relative, motion-offset search window into
// a frame-clamped rectangle (effective size + pad offsets) and streams every
// in-frame pixel address in raster order over a valid/ready handshake.
// Optional macro SWA_LINEAR_ADDR_EN adds a registered linear address
// (row*FRAME_W + col); without it addr_lin is constant 0.
module search_window_agen #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 48,
  parameter int BLK     = 8,
  parameter int IDX_W   = 3,
  parameter int OFF_W   = 4,
  parameter int DIM_W   = 5,
  parameter int COORD_W = 8,
  parameter int LIN_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  search_window_agen_if.master  bus
);

  localparam int BLK_SH = $clog2(BLK);
  localparam int AW     = COORD_W - 1;
  localparam logic signed [COORD_W-1:0] FH_S = COORD_W'(FRAME_H);
  localparam logic signed [COORD_W-1:0] FW_S = COORD_W'(FRAME_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_STREAM, S_DONE} state_t;

  state_t state_q, state_d;

  // Saturate a coordinate into [0, hi].
  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W-1:0] v,
    input logic signed [COORD_W-1:0] hi
  );
    if (v < 0)       return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Sign-extend a signed offset field to coordinate width.
  function automatic logic signed [COORD_W-1:0] sext_off(input logic [OFF_W-1:0] v);
    return {{(COORD_W-OFF_W){v[OFF_W-1]}}, v};
  endfunction

  // Latched request fields
  logic [IDX_W-1:0] blk_row_q, blk_row_d, blk_col_q, blk_col_d;
  logic [OFF_W-1:0] rel_row_q, rel_row_d, rel_col_q, rel_col_d;
  logic [OFF_W-1:0] off_row_q, off_row_d, off_col_q, off_col_d;
  logic [DIM_W-1:0] h_q, h_d, w_q, w_d;

  // Geometry results and stream state
  logic [DIM_W-1:0] eff_h_q, eff_h_d, eff_w_q, eff_w_d;
  logic [DIM_W-1:0] pad_row_q, pad_row_d, pad_col_q, pad_col_d;
  logic [AW-1:0]    cr0_q, cr0_d, cc0_q, cc0_d;
  logic [DIM_W-1:0] rcnt_q, rcnt_d, ccnt_q, ccnt_d;
  logic [AW-1:0]    addr_row_q, addr_row_d, addr_col_q, addr_col_d;
  logic [DIM_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;

  // Combinational rectangle arithmetic (consumed in CALC)
  logic signed [COORD_W-1:0] r0, r1, c0, c1, cr0, cr1, cc0, cc1;
  logic [DIM_W-1:0]          calc_eff_h, calc_eff_w, calc_pad_r, calc_pad_c;
  logic                      calc_empty;
  logic                      row_end, col_end, at_last;

  // Absolute rectangle, frame clamp, pad offsets and effective size.
  always_comb begin
    r0  = (COORD_W'(blk_row_q) << BLK_SH) + sext_off(rel_row_q) + sext_off(off_row_q);
    c0  = (COORD_W'(blk_col_q) << BLK_SH) + sext_off(rel_col_q) + sext_off(off_col_q);
    r1  = r0 + COORD_W'(h_q);
    c1  = c0 + COORD_W'(w_q);
    cr0 = clamp_coord(r0, FH_S);
    cr1 = clamp_coord(r1, FH_S);
    cc0 = clamp_coord(c0, FW_S);
    cc1 = clamp_coord(c1, FW_S);
    calc_pad_r = (r0 < 0) ? DIM_W'(cr0 - r0) : '0;
    calc_pad_c = (c0 < 0) ? DIM_W'(cc0 - c0) : '0;
    calc_eff_h = DIM_W'(cr1 - cr0);
    calc_eff_w = DIM_W'(cc1 - cc0);
    calc_empty = (calc_eff_h == '0) || (calc_eff_w == '0);
  end

  // End-of-row / end-of-window detection on the registered counters.
  always_comb begin
    row_end = (rcnt_q == eff_h_q - DIM_W'(1));
    col_end = (ccnt_q == eff_w_q - DIM_W'(1));
    at_last = row_end && col_end;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = S_CALC;
      S_CALC:   state_d = calc_empty ? S_DONE : S_STREAM;
      S_STREAM: if (bus.addr_ready && at_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.addr_valid = (state_q == S_STREAM);
    bus.done       = (state_q == S_DONE);
    bus.addr_last  = (state_q == S_STREAM) && at_last;
  end

  // Datapath next-state: latch request, load geometry, advance raster counters.
  always_comb begin
    blk_row_d  = blk_row_q;  blk_col_d  = blk_col_q;
    rel_row_d  = rel_row_q;  rel_col_d  = rel_col_q;
    off_row_d  = off_row_q;  off_col_d  = off_col_q;
    h_d        = h_q;        w_d        = w_q;
    eff_h_d    = eff_h_q;    eff_w_d    = eff_w_q;
    pad_row_d  = pad_row_q;  pad_col_d  = pad_col_q;
    cr0_d      = cr0_q;      cc0_d      = cc0_q;
    rcnt_d     = rcnt_q;     ccnt_d     = ccnt_q;
    addr_row_d = addr_row_q; addr_col_d = addr_col_q;
    win_row_d  = win_row_q;  win_col_d  = win_col_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          blk_row_d = bus.req_blk_row; blk_col_d = bus.req_blk_col;
          rel_row_d = bus.req_rel_row; rel_col_d = bus.req_rel_col;
          off_row_d = bus.req_off_row; off_col_d = bus.req_off_col;
          h_d       = bus.req_h;       w_d       = bus.req_w;
        end
      end
      S_CALC: begin
        eff_h_d    = calc_eff_h;
        eff_w_d    = calc_eff_w;
        pad_row_d  = calc_pad_r;
        pad_col_d  = calc_pad_c;
        cr0_d      = AW'(cr0);
        cc0_d      = AW'(cc0);
        rcnt_d     = '0;
        ccnt_d     = '0;
        addr_row_d = AW'(cr0);
        addr_col_d = AW'(cc0);
        win_row_d  = calc_pad_r;
        win_col_d  = calc_pad_c;
      end
      S_STREAM: begin
        // Everything holds while the downstream stalls; the final transfer
        // leaves the last beat parked on the outputs.
        if (bus.addr_ready && !at_last) begin
          if (col_end) begin
            ccnt_d     = '0;
            rcnt_d     = rcnt_q + DIM_W'(1);
            addr_col_d = cc0_q;
            addr_row_d = addr_row_q + AW'(1);
            win_col_d  = pad_col_q;
            win_row_d  = win_row_q + DIM_W'(1);
          end else begin
            ccnt_d     = ccnt_q + DIM_W'(1);
            addr_col_d = addr_col_q + AW'(1);
            win_col_d  = win_col_q + DIM_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_row_q <= '0; blk_col_q <= '0; rel_row_q <= '0; rel_col_q <= '0;
      off_row_q <= '0; off_col_q <= '0; h_q <= '0; w_q <= '0;
      eff_h_q <= '0; eff_w_q <= '0; pad_row_q <= '0; pad_col_q <= '0;
      cr0_q <= '0; cc0_q <= '0; rcnt_q <= '0; ccnt_q <= '0;
      addr_row_q <= '0; addr_col_q <= '0; win_row_q <= '0; win_col_q <= '0;
    end else begin
      blk_row_q <= blk_row_d; blk_col_q <= blk_col_d;
      rel_row_q <= rel_row_d; rel_col_q <= rel_col_d;
      off_row_q <= off_row_d; off_col_q <= off_col_d;
      h_q <= h_d; w_q <= w_d;
      eff_h_q <= eff_h_d; eff_w_q <= eff_w_d;
      pad_row_q <= pad_row_d; pad_col_q <= pad_col_d;
      cr0_q <= cr0_d; cc0_q <= cc0_d;
      rcnt_q <= rcnt_d; ccnt_q <= ccnt_d;
      addr_row_q <= addr_row_d; addr_col_q <= addr_col_d;
      win_row_q <= win_row_d; win_col_q <= win_col_d;
    end
  end

  assign bus.eff_h    = eff_h_q;
  assign bus.eff_w    = eff_w_q;
  assign bus.pad_row  = pad_row_q;
  assign bus.pad_col  = pad_col_q;
  assign bus.addr_row = addr_row_q;
  assign bus.addr_col = addr_col_q;
  assign bus.win_row  = win_row_q;
  assign bus.win_col  = win_col_q;

`ifdef SWA_LINEAR_ADDR_EN
  logic [LIN_W-1:0] addr_lin_q, addr_lin_d;

  // Linear address tracks the next row/col so it changes in the same cycle.
  always_comb begin
    addr_lin_d = LIN_W'(addr_row_d) * LIN_W'(FRAME_W) + LIN_W'(addr_col_d);
  end

  // Linear address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_lin_q <= '0;
    else        addr_lin_q <= addr_lin_d;
  end

  assign bus.addr_lin = addr_lin_q;
`else
  assign bus.addr_lin = {LIN_W{1'b0}};
`endif

endmodule

// File: tb/tb_search_window_agen.sv
// tb_search_window_agen: directed transactions with a reference model that
// queues the expected address beats, checked as the DUT transfers them.
module tb_search_window_agen;

  localparam int FRAME_W = 64;
  localparam int FRAME_H = 48;
  localparam int BLK     = 8;

  logic clk = 1'b0;
  logic rst_n;

  search_window_agen_if bus ();

  search_window_agen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] pk(input int row, input int col, input int wr,
                                     input int wc, input int last, input int lin);
    return {3'b0, 7'(row), 7'(col), 5'(wr), 5'(wc), 1'(last), 12'(lin)};
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int lin_of(input int row, input int col);
`ifdef SWA_LINEAR_ADDR_EN
    return row * FRAME_W + col;
`else
    return 0 * (row + col);
`endif
  endfunction

  // Reference model: queue every beat the request should produce.
  task automatic model_push(input int br, input int bc, input int rr, input int rc,
                            input int orr, input int oc, input int h, input int w);
    int r0, c0, cr0, cr1, cc0, cc1, pr, pc, eh, ew;
    r0  = br * BLK + rr + orr;
    c0  = bc * BLK + rc + oc;
    cr0 = clampi(r0, FRAME_H);  cr1 = clampi(r0 + h, FRAME_H);
    cc0 = clampi(c0, FRAME_W);  cc1 = clampi(c0 + w, FRAME_W);
    pr  = (r0 < 0) ? cr0 - r0 : 0;
    pc  = (c0 < 0) ? cc0 - c0 : 0;
    eh  = cr1 - cr0;
    ew  = cc1 - cc0;
    if (eh > 0 && ew > 0)
      for (int r = 0; r < eh; r++)
        for (int c = 0; c < ew; c++)
          exp_q.push_back(pk(cr0 + r, cc0 + c, pr + r, pc + c,
                             (r == eh - 1 && c == ew - 1) ? 1 : 0,
                             lin_of(cr0 + r, cc0 + c)));
  endtask

  function automatic logic [39:0] obs_beat();
    return pk(int'(bus.addr_row), int'(bus.addr_col), int'(bus.win_row),
              int'(bus.win_col), int'(bus.addr_last), int'(bus.addr_lin));
  endfunction

  task automatic run_txn(input string nm,
                         input int br, input int bc, input int rr, input int rc,
                         input int orr, input int oc, input int h, input int w,
                         input int e_eh, input int e_ew, input int e_pr, input int e_pc,
                         input int e_beats,
                         input int f_r, input int f_c, input int f_wr, input int f_wc,
                         input int l_r, input int l_c, input int l_lin,
                         input bit bp, input int abort_after, input bit poke);
    int k, nbeats, done_k, last_r, last_c, last_lin;
    bit stalled;
    logic [39:0] obs, held, expv;
    model_push(br, bc, rr, rc, orr, oc, h, w);
    @(negedge clk);
    bus.req_blk_row = 3'(br); bus.req_blk_col = 3'(bc);
    bus.req_rel_row = 4'(rr); bus.req_rel_col = 4'(rc);
    bus.req_off_row = 4'(orr); bus.req_off_col = 4'(oc);
    bus.req_h = 5'(h); bus.req_w = 5'(w);
    bus.req_valid = 1'b1;
    bus.addr_ready = 1'b1;
    chk({nm, ".req_ready_idle"}, bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // CALC cycle: optionally present a conflicting request that must be ignored
    bus.req_valid = poke;
    if (poke) begin
      bus.req_blk_row = 3'd1; bus.req_blk_col = 3'd1;
      bus.req_h = 5'd3; bus.req_w = 5'd3;
    end
    chk({nm, ".calc_no_valid"}, bus.addr_valid, 0);
    chk({nm, ".calc_busy"}, bus.req_ready, 0);
    k = 1; nbeats = 0; done_k = -1; stalled = 0;
    last_r = -1; last_c = -1; last_lin = -1; held = '0;
    while (k < 2000) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      bus.req_valid = 1'b0;
      if (bus.done) begin
        done_k = k;
        break;
      end
      if (bus.addr_valid) begin
        obs = obs_beat();
        if (stalled) chk({nm, ".stall_hold"}, obs, held);
        bus.addr_ready = bp ? ((k % 2) == 0) : 1'b1;
        if (bus.addr_ready) begin
          if (nbeats == 0) begin
            chk({nm, ".first_cycle"}, k, 2);
            chk({nm, ".first_pos"},
                {bus.addr_row, bus.addr_col, bus.win_row, bus.win_col},
                {7'(f_r), 7'(f_c), 5'(f_wr), 5'(f_wc)});
          end
          expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          chk({nm, ".beat"}, obs, expv);
          last_r = int'(bus.addr_row); last_c = int'(bus.addr_col);
          last_lin = int'(bus.addr_lin);
          nbeats++;
          stalled = 0;
          if (nbeats == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            chk({nm, ".abort_valid"}, bus.addr_valid, 0);
            chk({nm, ".abort_done"}, bus.done, 0);
            chk({nm, ".abort_ready"}, bus.req_ready, 1);
            chk({nm, ".abort_regs"},
                {bus.eff_h, bus.eff_w, bus.pad_row, bus.addr_row, bus.addr_col, bus.addr_lin}, 0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk({nm, ".abort_no_done"}, bus.done, 0);
            chk({nm, ".abort_idle"}, bus.req_ready, 1);
            bus.addr_ready = 1'b1;
            return;
          end
        end else begin
          held = obs;
          stalled = 1;
        end
      end
    end
    chk({nm, ".done_cycle"}, done_k, 2 + e_beats + (bp ? e_beats - 1 : 0));
    chk({nm, ".beat_count"}, nbeats, e_beats);
    chk({nm, ".queue_drained"}, exp_q.size(), 0);
    if (nbeats > 0) chk({nm, ".last_pos"}, {last_r, last_c}, {l_r, l_c});
    if (l_lin >= 0) chk({nm, ".last_lin"}, last_lin, l_lin);
    chk({nm, ".eff"}, {bus.eff_h, bus.eff_w}, {5'(e_eh), 5'(e_ew)});
    chk({nm, ".pad"}, {bus.pad_row, bus.pad_col}, {5'(e_pr), 5'(e_pc)});
    @(negedge clk);
    chk({nm, ".done_pulse"}, bus.done, 0);
    chk({nm, ".ready_back"}, bus.req_ready, 1);
    chk({nm, ".result_hold"}, {bus.eff_h, bus.eff_w}, {5'(e_eh), 5'(e_ew)});
    bus.addr_ready = 1'b1;
  endtask

  initial begin
    int br_lin;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_blk_row = '0; bus.req_blk_col = '0;
    bus.req_rel_row = '0; bus.req_rel_col = '0;
    bus.req_off_row = '0; bus.req_off_col = '0;
    bus.req_h = '0; bus.req_w = '0;
    bus.addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", bus.req_ready, 1);
    chk("reset.ctrl", {bus.addr_valid, bus.addr_last, bus.done}, 0);
    chk("reset.regs", {bus.eff_h, bus.eff_w, bus.pad_row, bus.pad_col,
                       bus.addr_row, bus.addr_col, bus.win_row, bus.win_col, bus.addr_lin}, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef SWA_LINEAR_ADDR_EN
    br_lin = 3071;
`else
    br_lin = 0;
`endif
    //       name        br bc rr  rc  or  oc  h   w   eh ew pr pc  N    fr fc fwr fwc lr lc lin   bp abort poke
    run_txn("interior",  2, 3, -2, -2,  0,  0, 12, 12, 12,12, 0, 0, 144, 14,22, 0, 0, 25,33, -1,   0, 0, 0);
    run_txn("top_left",  0, 0, -2, -2, -3, -1, 12, 12,  7, 9, 5, 3,  63,  0, 0, 5, 3,  6, 8, -1,   0, 0, 0);
    run_txn("bot_right", 5, 7, -2, -2,  4,  4, 12, 12,  6, 6, 0, 0,  36, 42,58, 0, 0, 47,63, br_lin,0, 0, 1);
    run_txn("outside",   0, 0, -2,  0, -8,  0,  2, 12,  0,12,10, 0,   0,  0, 0, 0, 0,  0, 0, -1,   0, 0, 0);
    run_txn("backpress", 2, 3, -2, -2,  0,  0, 12, 12, 12,12, 0, 0, 144, 14,22, 0, 0, 25,33, -1,   1, 0, 0);
    run_txn("abort",     2, 3, -2, -2,  0,  0, 12, 12, 12,12, 0, 0, 144, 14,22, 0, 0, 25,33, -1,   0, 10,0);
    run_txn("recover",   0, 0, -2, -2, -3, -1, 12, 12,  7, 9, 5, 3,  63,  0, 0, 5, 3,  6, 8, -1,   0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/search_window_agen.md
Name: search_window_agen

Overview:
- Parameterised successor of the combinational block-address/size/pad calculator in the ME search path.
- Accepts one rectangle request per transaction, given as a window relative to a block origin plus a signed motion offset.
- Computes the absolute rectangle, clamps it to the frame, and derives pad offsets and effective size.
- Streams every in-frame pixel address with a valid/ready handshake to the reference-frame SRAM reader, which fills the padded search buffer.

Parameters:
FRAME_W, 64, frame width in pixels
FRAME_H, 48, frame height in pixels
BLK, 8, block edge in pixels (power of 2)
IDX_W, 3, width of block index inputs
OFF_W, 4, width of signed motion offset
DIM_W, 5, width of window height/width and counters
COORD_W, 8, signed internal coordinate width
LIN_W, 12, linear address width (>= clog2(FRAME_W*FRAME_H))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block idle, can accept
req_blk_row  in  IDX_W  block row index (unsigned)
req_blk_col  in  IDX_W  block column index (unsigned)
req_rel_row  in  OFF_W  signed window start row relative to block origin
req_rel_col  in  OFF_W  signed window start col relative to block origin
req_off_row  in  OFF_W  signed motion-vector row offset
req_off_col  in  OFF_W  signed motion-vector col offset
req_h  in  DIM_W  window height (0 allowed)
req_w  in  DIM_W  window width (0 allowed)
eff_h  out  DIM_W  clamped window height, registered
eff_w  out  DIM_W  clamped window width, registered
pad_row  out  DIM_W  rows cut above the frame
pad_col  out  DIM_W  cols cut left of the frame
addr_valid  out  1  address beat valid
addr_ready  in  1  downstream accepts beat
addr_row  out  COORD_W-1  absolute pixel row
addr_col  out  COORD_W-1  absolute pixel col
win_row  out  DIM_W  row inside requested window (pad_row + row counter)
win_col  out  DIM_W  col inside requested window (pad_col + col counter)
addr_lin  out  LIN_W  linear address (see Optional Feature)
addr_last  out  1  final beat of transaction
done  out  1  one-cycle pulse, transaction complete

Behaviour:
- Clock/reset: one clock clk. rst_n is asynchronous and active-low. Reset puts the FSM in IDLE and clears every registered output to 0; req_ready is 1 after reset.
- FSM states: IDLE, CALC, STREAM, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch all request fields and go to CALC.
- CALC (1 cycle), all arithmetic signed COORD_W with sign-extended inputs:
  - r0 = blk_row*BLK + rel_row + off_row; r1 = r0 + h (exclusive). Same for columns with FRAME_W.
  - Clamp each of r0 and r1 to [0, FRAME_H]; clamp c0 and c1 to [0, FRAME_W].
  - pad_row = cr0 - r0 when r0 < 0, else 0; pad_col likewise.
  - eff_h = cr1 - cr0; eff_w = cc1 - cc0.
  - Register all results; clear row/col counters.
  - If eff_h == 0 or eff_w == 0, go to DONE with no beats; otherwise go to STREAM.
- STREAM:
  - addr_valid=1; addr_row = cr0 + rcnt; addr_col = cc0 + ccnt.
  - Beat order is raster: column fastest, then row.
  - A beat transfers on addr_valid && addr_ready. On transfer, ccnt increments; on ccnt wrap to 0, rcnt increments.
  - addr_last=1 when rcnt = eff_h-1 and ccnt = eff_w-1. A transfer of the last beat goes to DONE.
  - While addr_ready=0, all addr_* and win_* hold stable.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: request accepted at cycle T; first beat valid at T+2; done at T+2 for an empty rectangle.
- Throughput: one beat per cycle when addr_ready stays high. A transaction of N beats ends with done at T+2+N. Back-to-back requests are separated by at least 1 idle cycle.
- req_valid while not in IDLE is ignored (req_ready=0). Request fields are sampled only at acceptance.
- Asserting rst_n low mid-STREAM aborts immediately: addr_valid drops, and no done is issued.
- eff_h, eff_w, pad_row and pad_col stay valid from CALC until the next CALC.

Optional Feature:
- Macro SWA_LINEAR_ADDR_EN.
- Defined: addr_lin = addr_row*FRAME_W + addr_col, registered alongside addr_row/addr_col and equally stable under backpressure.
- Undefined: addr_lin is tied to 0 and no multiplier/adder logic is synthesised. All other behaviour is identical.

Test Plan:
- Interior block: blk (2,3), rel (-2,-2), off (0,0), h=w=12, addr_ready=1.
  - eff 12x12, pad (0,0).
  - First beat (14,22) at T+2; 144 beats; last beat (25,33) with addr_last; done at T+146.
- Top-left clip: blk (0,0), rel (-2,-2), off (-3,-1), h=w=12.
  - eff_h=7, eff_w=9, pad (5,3).
  - First beat (0,0) with win (5,3); 63 beats; last (6,8).
- Bottom-right clip: blk (5,7), rel (-2,-2), off (+4,+4), h=w=12.
  - eff 6x6, pad (0,0).
  - First (42,58); last (47,63); 36 beats.
  - With SWA_LINEAR_ADDR_EN, last addr_lin=3071.
- Fully outside window: blk (0,0), rel (-2,0), off (-8,0), h=2, w=12.
  - eff_h=0; no addr_valid.
  - done at T+2; req_ready back at T+3.
- Backpressure: interior case with addr_ready low on alternate cycles.
  - Beats stay stable while stalled; sequence identical to the first case.
  - done at T+2+287 (144 transfers, 143 stalls).
- Reset mid-stream: assert rst_n low after beat 10 of the first case.
  - All outputs 0 at once, no done.
  - After release, req_ready=1 and a new request streams correctly.
